adc_capture_ctrl: RTL and testbench
===================================

// Module: adc_capture_ctrl
// PURPOSE
//  Parametrised trigger/capture engine behind the ADC IDDR de-mux (ad9434 path), NUM_CH channels.
//  Ring buffer keeps i_pre_len pre-trigger words; rising i_trig opens a window of i_us_capture us.
//  Window is counted in clk_200m_in cycles; captured words stream out on a valid/ready port
//  toward the PS DDR writer, with tlast on the final word, overflow and out-of-range flags.
// PARAMETERS
//  DATA_W      12   bits per channel sample
//  NUM_CH      1    channels packed per word; word width W = NUM_CH*DATA_W, ch0 in LSBs
//  CYC_PER_US  200  clk_200m_in cycles per microsecond (>=2)
//  US_W        10   width of i_us_capture
//  FIFO_DEPTH  512  ring/FIFO depth in words (power of 2); AW = $clog2(FIFO_DEPTH)
// PORTS
//  clk_200m_in  in   1       single clock for all logic
//  rst          in   1       asynchronous, active-high reset
//  i_arm        in   1       1-cycle pulse; IDLE -> ARMED; ignored in other states
//  i_trig       in   1       level trigger; rising edge is the event
//  i_us_capture in   US_W    post-trigger window in us, latched on trigger
//  i_pre_len    in   AW      pre-trigger words to keep (0..FIFO_DEPTH-1), sampled while ARMED
//  i_sample     in   W       packed ADC word, synchronous to clk_200m_in
//  i_sample_vld in   1       i_sample valid this cycle
//  i_or         in   NUM_CH  per-channel ADC out-of-range, qualified by i_sample_vld
//  o_tdata      out  W       stream data
//  o_tvalid     out  1       stream valid
//  i_tready     in   1       stream ready; beat = o_tvalid & i_tready
//  o_tlast      out  1       with final beat of a capture
//  o_busy       out  1       state != IDLE
//  o_cap_done   out  1       1-cycle pulse in DONE
//  o_ovf        out  1       sticky: word dropped (FIFO full); cleared by i_arm
//  o_or_seen    out  NUM_CH  sticky per-channel OR over written words; cleared by i_arm
// BEHAVIOUR
//  Reset: state IDLE, pointers/occupancy/counters 0, all outputs 0; applies mid-capture too.
//  Edge detect: trig_q <= i_trig each cycle; trig_rise = i_trig & ~trig_q; ignored outside ARMED.
//  IDLE: outputs idle; i_arm -> ARMED, clears pointers, occupancy, o_ovf, o_or_seen.
//  ARMED: each vld word written; if occupancy == i_pre_len, oldest word dropped (rd++)
//    Net: buffer holds min(written, i_pre_len) words; o_tvalid=0.
//    trig_rise & us==0 -> DRAIN, trigger-cycle word not written.
//    trig_rise & us>0  -> trigger-cycle word written without drop (first post word), cnt=1,
//    us_cnt=0 -> CAPTURE.
//  CAPTURE: vld words written; cnt wraps at CYC_PER_US-1 and increments us_cnt
//    Exit: cnt==CYC_PER_US-1 & us_cnt==us_lat-1 -> DRAIN.
//    Window = CYC_PER_US*us_lat cycles including the trigger cycle; further triggers ignored.
//  Output: FWFT from CAPTURE on; o_tvalid = occupancy!=0.
//    o_tdata/o_tlast hold stable while o_tvalid & !i_tready.
//  Write+beat same cycle: occupancy unchanged.
//    Write with occupancy==FIFO_DEPTH and no beat: word dropped, o_ovf<=1.
//  DRAIN: no writes; o_tlast = o_tvalid & occupancy==1; beat with tlast -> DONE
//    DRAIN entered with occupancy 0 -> DONE, no beat.
//  DONE: o_cap_done=1 one cycle -> IDLE. o_or_seen |= i_or on every written word.
// TESTING
//  T1 pre=4, us=1, ramp word=cycle idx, trig at 50, tready=1 -> 204 beats 46..249, tlast on 249, cap_done next cyc
//  T2 pre=0, us=3, tready=0 until DRAIN -> 512 beats 50..561, o_ovf=1, tlast on 561
//  T3 pre=0, us=0, trigger -> no o_tvalid, o_cap_done 1 cycle, o_busy falls, no tlast
//  T4 arm, 2 words (7,8), trig at next word 9, pre=8, us=1 -> first beats 7,8,9; 202 beats total
//  T5 rst pulse mid-CAPTURE -> all outputs 0 same cycle; re-arm + T1 stimulus reproduces T1
//  T6 i_or[0]=1 on one window word, 2nd i_trig edge in CAPTURE -> o_or_seen=1, length unchanged; i_arm clears

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// ADC trigger/capture engine: pre-trigger ring, timed post-trigger window, FWFT stream out.
// Ports: clk_200m_in/rst; i_arm/i_trig/i_us_capture/i_pre_len control; i_sample/i_sample_vld/i_or
// ADC input; o_tdata/o_tvalid/i_tready/o_tlast stream; o_busy/o_cap_done/o_ovf/o_or_seen status.
module adc_capture_ctrl #(
  parameter int DATA_W     = 12,
  parameter int NUM_CH     = 1,
  parameter int CYC_PER_US = 200,
  parameter int US_W       = 10,
  parameter int FIFO_DEPTH = 512
) (
  input  logic                         clk_200m_in,
  input  logic                         rst,
  input  logic                         i_arm,
  input  logic                         i_trig,
  input  logic [US_W-1:0]              i_us_capture,
  input  logic [$clog2(FIFO_DEPTH)-1:0] i_pre_len,
  input  logic [NUM_CH*DATA_W-1:0]     i_sample,
  input  logic                         i_sample_vld,
  input  logic [NUM_CH-1:0]            i_or,
  output logic [NUM_CH*DATA_W-1:0]     o_tdata,
  output logic                         o_tvalid,
  input  logic                         i_tready,
  output logic                         o_tlast,
  output logic                         o_busy,
  output logic                         o_cap_done,
  output logic                         o_ovf,
  output logic [NUM_CH-1:0]            o_or_seen
);

  localparam int W  = NUM_CH * DATA_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CYC_PER_US);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  logic            trig_q;
  logic [W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     occ;
  logic [CW-1:0]   cnt;
  logic [US_W-1:0] us_cnt;
  logic [US_W-1:0] us_lat;

  logic trig_rise;
  logic beat;
  logic full;
  logic wr_req;
  logic drop_old;
  logic wr_en;
  logic rd_adv;
  logic ovf_set;

  assign trig_rise = i_trig & ~trig_q;
  assign full      = (occ == (AW+1)'(FIFO_DEPTH));
  assign o_tvalid  = ((state == S_CAPTURE) || (state == S_DRAIN)) && (occ != '0);
  assign o_tlast   = (state == S_DRAIN) && (occ == (AW+1)'(1));
  assign o_tdata   = o_tvalid ? mem[rd_ptr] : '0;
  assign o_busy    = (state != S_IDLE);
  assign o_cap_done = (state == S_DONE);
  assign beat      = o_tvalid & i_tready;

  // A pre-trigger write at the retained depth evicts the oldest word;
  // the trigger-cycle word is kept in addition to the pre-trigger history.
  always_comb begin
    wr_req   = 1'b0;
    drop_old = 1'b0;
    unique case (state)
      S_ARMED: begin
        if (trig_rise) begin
          wr_req = i_sample_vld && (i_us_capture != '0);
        end else begin
          wr_req   = i_sample_vld;
          drop_old = i_sample_vld && (occ == {1'b0, i_pre_len});
        end
      end
      S_CAPTURE: wr_req = i_sample_vld;
      default: ;
    endcase
  end

  // A full FIFO still accepts a word when a beat frees a slot this cycle.
  assign wr_en   = wr_req & (~full | beat);
  assign ovf_set = wr_req & full & ~beat;
  assign rd_adv  = beat | drop_old;

  always_ff @(posedge clk_200m_in) begin
    if (wr_en) mem[wr_ptr] <= i_sample;
  end

  always_ff @(posedge clk_200m_in or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      trig_q    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      cnt       <= '0;
      us_cnt    <= '0;
      us_lat    <= '0;
      o_ovf     <= 1'b0;
      o_or_seen <= '0;
    end else begin
      trig_q <= i_trig;
      if ((state == S_IDLE) && i_arm) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        occ       <= '0;
        o_ovf     <= 1'b0;
        o_or_seen <= '0;
      end else begin
        if (wr_en) begin
          wr_ptr    <= wr_ptr + AW'(1);
          o_or_seen <= o_or_seen | i_or;
        end
        if (rd_adv) rd_ptr <= rd_ptr + AW'(1);
        if (wr_en && !rd_adv) occ <= occ + (AW+1)'(1);
        else if (!wr_en && rd_adv) occ <= occ - (AW+1)'(1);
        if (ovf_set) o_ovf <= 1'b1;
      end

      unique case (state)
        S_IDLE: begin
          if (i_arm) state <= S_ARMED;
        end
        S_ARMED: begin
          if (trig_rise) begin
            if (i_us_capture == '0) begin
              state <= S_DRAIN;
            end else begin
              us_lat <= i_us_capture;
              cnt    <= CW'(1);
              us_cnt <= '0;
              state  <= S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          if (cnt == CW'(CYC_PER_US - 1)) begin
            cnt <= '0;
            if (us_cnt == us_lat - US_W'(1)) state <= S_DRAIN;
            else us_cnt <= us_cnt + US_W'(1);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          if ((occ == '0) || (beat && o_tlast)) state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: queue-based reference model checked every cycle,
// directed capture scenarios with literal expectations, then randomized captures.
module tb_adc_capture_ctrl;

  localparam int DATA_W = 12;
  localparam int NUM_CH = 1;
  localparam int CYC    = 200;
  localparam int US_W   = 10;
  localparam int DEPTH  = 512;
  localparam int W      = NUM_CH * DATA_W;
  localparam int AW     = $clog2(DEPTH);
  localparam int PW     = 5 + NUM_CH + W;

  localparam int P_IDLE  = 0;
  localparam int P_ARMED = 1;
  localparam int P_CAP   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              i_arm = 1'b0;
  logic              i_trig = 1'b0;
  logic [US_W-1:0]   i_us_capture = '0;
  logic [AW-1:0]     i_pre_len = '0;
  logic [W-1:0]      i_sample = '0;
  logic              i_sample_vld = 1'b0;
  logic [NUM_CH-1:0] i_or = '0;
  logic [W-1:0]      o_tdata;
  logic              o_tvalid;
  logic              i_tready = 1'b0;
  logic              o_tlast;
  logic              o_busy;
  logic              o_cap_done;
  logic              o_ovf;
  logic [NUM_CH-1:0] o_or_seen;

  adc_capture_ctrl #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CYC_PER_US(CYC),
    .US_W(US_W), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_200m_in(clk), .rst(rst), .i_arm(i_arm), .i_trig(i_trig),
    .i_us_capture(i_us_capture), .i_pre_len(i_pre_len),
    .i_sample(i_sample), .i_sample_vld(i_sample_vld), .i_or(i_or),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .i_tready(i_tready),
    .o_tlast(o_tlast), .o_busy(o_busy), .o_cap_done(o_cap_done),
    .o_ovf(o_ovf), .o_or_seen(o_or_seen)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  int             m_mode = P_IDLE;
  logic [W-1:0]   q[$];
  bit             m_ovf = 1'b0;
  logic [NUM_CH-1:0] m_or = '0;
  bit             tprev = 1'b0;
  int             rem = 0;
  int             edge_n = 0;
  int             last_edge = -1;
  int             done_edge = -2;
  int             done_seen = 0;
  logic [W-1:0]   log_d[$];
  bit             log_l[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] dut_pack();
    return {o_tvalid, o_tlast, o_busy, o_cap_done, o_ovf, o_or_seen, o_tdata};
  endfunction

  task automatic m_push();
    q.push_back(i_sample);
    m_or = m_or | i_or;
  endtask

  task automatic model_step();
    bit rise, vb, lb, bt;
    int n;
    edge_n++;
    if (rst) begin
      m_mode = P_IDLE;
      q.delete();
      m_ovf = 1'b0;
      m_or = '0;
      tprev = 1'b0;
      return;
    end
    rise = i_trig && !tprev;
    n = q.size();
    vb = (m_mode == P_CAP || m_mode == P_DRAIN) && n != 0;
    lb = (m_mode == P_DRAIN) && n == 1;
    bt = vb && i_tready;
    if (bt) begin
      log_d.push_back(q[0]);
      log_l.push_back(lb);
      if (lb) last_edge = edge_n;
    end
    case (m_mode)
      P_IDLE: if (i_arm) begin
        q.delete();
        m_ovf = 1'b0;
        m_or = '0;
        m_mode = P_ARMED;
      end
      P_ARMED: begin
        if (rise) begin
          if (i_us_capture == 0) m_mode = P_DRAIN;
          else begin
            if (i_sample_vld) m_push();
            rem = int'(i_us_capture) * CYC - 1;
            m_mode = P_CAP;
          end
        end else if (i_sample_vld) begin
          m_push();
          while (q.size() > int'(i_pre_len)) void'(q.pop_front());
        end
      end
      P_CAP: begin
        if (bt) void'(q.pop_front());
        if (i_sample_vld) begin
          if (q.size() < DEPTH) m_push();
          else m_ovf = 1'b1;
        end
        rem--;
        if (rem == 0) m_mode = P_DRAIN;
      end
      P_DRAIN: begin
        if (bt) void'(q.pop_front());
        if (n == 0 || (bt && lb)) begin
          m_mode = P_DONE;
          done_edge = edge_n;
        end
      end
      default: m_mode = P_IDLE;
    endcase
    tprev = i_trig;
  endtask

  function automatic logic [PW-1:0] model_pack();
    bit v;
    logic [W-1:0] d;
    v = (m_mode == P_CAP || m_mode == P_DRAIN) && q.size() != 0;
    d = v ? q[0] : '0;
    return {v, (m_mode == P_DRAIN) && q.size() == 1, m_mode != P_IDLE,
            m_mode == P_DONE, m_ovf, m_or, d};
  endfunction

  always @(posedge clk) begin
    logic [PW-1:0] a, e;
    model_step();
    #2;
    a = dut_pack();
    e = model_pack();
    if (o_cap_done === 1'b1) done_seen++;
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL cycle t=%0t {vld,last,busy,done,ovf,or,data} got %h want %h",
               $time, a, e);
    end
  end

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    done_seen = 0;
    last_edge = -1;
    done_edge = -2;
  endtask

  task automatic run_cap(input int pre, input int us, input int trig_at, input int base,
                         input bit hold_rdy, input int or_at, input int retrig_at,
                         input int rst_at);
    bit fin = 1'b0;
    clear_log();
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(negedge clk);
      if (c > 1 && m_mode == P_IDLE && !rst) fin = 1'b1;
      else begin
        i_arm = (c == 0);
        i_sample_vld = (c > 0);
        i_sample = W'(c + base);
        i_trig = (c >= trig_at && c < trig_at + 20) ||
                 (c >= retrig_at && c < retrig_at + 5);
        i_or = '0;
        i_or[0] = (c == or_at);
        i_tready = hold_rdy ? (m_mode == P_DRAIN) : 1'b1;
        i_us_capture = US_W'(us);
        i_pre_len = AW'(pre);
        if (c == rst_at) begin
          rst = 1'b1;
          #1;
          chk("rst_outputs_zero", 64'(dut_pack()), 64'd0);
        end
        if (c == rst_at + 2) rst = 1'b0;
      end
    end
    chk("capture_finished", 64'(fin), 64'd1);
  endtask

  task automatic chk_log(input string nm, input int n, input int first, input int last);
    int nl = 0;
    foreach (log_l[i]) nl += int'(log_l[i]);
    chk({nm, "_beats"}, 64'(log_d.size()), 64'(n));
    chk({nm, "_tlast_cnt"}, 64'(nl), 64'd1);
    if (log_d.size() > 0) begin
      chk({nm, "_first"}, 64'(log_d[0]), 64'(first));
      chk({nm, "_last"}, 64'(log_d[$]), 64'(last));
      chk({nm, "_last_flag"}, 64'(log_l[$]), 64'd1);
    end
    chk({nm, "_done_after_tlast"}, 64'(done_edge), 64'(last_edge));
    chk({nm, "_done_pulses"}, 64'(done_seen), 64'd1);
  endtask

  task automatic run_rand(input int ready_pct, input int us_lo, input int us_hi);
    bit fin = 1'b0;
    int pre = $urandom_range(0, 12);
    int us = $urandom_range(us_lo, us_hi);
    int trig_at = $urandom_range(1, 30);
    clear_log();
    for (int c = 0; c < 20000 && !fin; c++) begin
      @(negedge clk);
      if (c > 1 && m_mode == P_IDLE) fin = 1'b1;
      else begin
        i_arm = (c == 0) || ($urandom_range(0, 49) == 0);
        i_sample_vld = ($urandom_range(0, 3) != 0);
        i_sample = W'($urandom);
        i_or = NUM_CH'($urandom_range(0, 15) == 0);
        i_tready = ($urandom_range(0, 99) < ready_pct);
        i_trig = (c >= trig_at) ? ($urandom_range(0, 7) != 0) : 1'b0;
        i_us_capture = US_W'(us);
        i_pre_len = AW'(pre);
      end
    end
    chk("rand_finished", 64'(fin), 64'd1);
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 64'(dut_pack()), 64'd0);

    // T1: 4 pre words + one 200-cycle window
    run_cap(4, 1, 50, 0, 1'b0, -1, -100, -10);
    chk_log("t1", 204, 46, 249);

    // T2: stalled sink, 600-word window into 512 entries
    run_cap(0, 3, 50, 0, 1'b1, -1, -100, -10);
    chk_log("t2", 512, 50, 561);
    chk("t2_ovf", 64'(o_ovf), 64'd1);

    // T3: zero-length window
    run_cap(0, 0, 50, 0, 1'b0, -1, -100, -10);
    chk("t3_beats", 64'(log_d.size()), 64'd0);
    chk("t3_done_pulses", 64'(done_seen), 64'd1);
    chk("t3_busy", 64'(o_busy), 64'd0);

    // T4: fewer words than pre length before trigger
    run_cap(8, 1, 3, 6, 1'b0, -1, -100, -10);
    chk("t4_beats", 64'(log_d.size()), 64'd202);
    if (log_d.size() >= 3) begin
      chk("t4_b0", 64'(log_d[0]), 64'd7);
      chk("t4_b1", 64'(log_d[1]), 64'd8);
      chk("t4_b2", 64'(log_d[2]), 64'd9);
    end

    // T5: reset mid-capture, then T1 again
    run_cap(4, 1, 50, 0, 1'b0, -1, -100, 120);
    chk("t5_idle", 64'(o_busy), 64'd0);
    run_cap(4, 1, 50, 0, 1'b0, -1, -100, -10);
    chk_log("t5", 204, 46, 249);

    // T6: OR flag in window, retrigger ignored, arm clears flag
    run_cap(4, 1, 50, 0, 1'b0, 100, 150, -10);
    chk_log("t6", 204, 46, 249);
    chk("t6_or_seen", 64'(o_or_seen), 64'd1);
    @(negedge clk);
    i_arm = 1'b1;
    @(negedge clk);
    i_arm = 1'b0;
    chk("t6_or_cleared", 64'(o_or_seen), 64'd0);
    chk("t6_rearmed", 64'(o_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 10; k++) run_rand(70, 0, 2);
    run_rand(20, 4, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
